mem_port_arbiter: RTL and testbench

Arbitrates one single-ported, fixed-latency unified memory between the instruction-fetch port and the data-memory port of the pipelined MIPS core. Each port uses a request/ready handshake, and the pipeline stalls a stage while its request is pending. Data accesses have priority over fetches, because the MEM-stage instruction is older than the IF-stage instruction. The block sits between the IF/MEM pipeline stages and the memory, replacing separate instruction and data memories.

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//    Shares one single-ported, fixed-latency memory between the instruction
//    fetch port (IF) and the data-memory port (DM) of a pipelined MIPS core.
//    DM wins any conflict because the MEM-stage instruction is the older one.
//    Each access holds the memory for MEM_LAT cycles and then pulses the
//    matching ready for one cycle. That ready cycle is always an IDLE cycle.
//
// Parameters
//    MEM_LAT   memory access latency in cycles, legal range 1..15
//
// Ports
//    clk, rst               clock, asynchronous active-high reset
//    if_req/if_addr         fetch request (held until if_ready) and byte address
//    if_rdata/if_ready      fetched word (held) and one-cycle completion pulse
//    dm_read/dm_write       data request; a write wins when both are high
//    dm_addr/dm_wdata       data byte address and write data
//    dm_rdata/dm_ready      read data (held, writes leave it alone) and pulse
//    mem_addr/mem_wdata     memory address and write data (held while idle)
//    mem_read/mem_write     memory strobes, high for the whole access
//    mem_rdata              memory read data, valid on the last access cycle
//    grant                  current owner: 00 none, 01 IF, 10 DM
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        dm_read,
   input  logic        dm_write,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  grant
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACC_IF = 2'd1,
      ACC_DM = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

   state_t     state_reg;
   logic [3:0] cnt_reg;

   logic dm_req;
   logic if_elig;
   logic dm_elig;

   // A port whose ready is high right now has just been served and the
   // pipeline has not yet had a chance to drop its request, so it must not
   // be granted again in this cycle.
   assign dm_req  = dm_read | dm_write;
   assign if_elig = if_req & ~if_ready;
   assign dm_elig = dm_req & ~dm_ready;

   // mem_addr, mem_wdata and mem_write double as the latched request: they
   // are loaded at grant time and simply hold afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         if_rdata  <= 32'd0;
         if_ready  <= 1'b0;
         dm_rdata  <= 32'd0;
         dm_ready  <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         grant     <= 2'b00;
      end else begin
         if_ready <= 1'b0;
         dm_ready <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (dm_elig) begin
                  state_reg <= ACC_DM;
                  cnt_reg   <= CNT_INIT;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  mem_write <= dm_write;
                  mem_read  <= ~dm_write;
                  grant     <= 2'b10;
               end else if (if_elig) begin
                  state_reg <= ACC_IF;
                  cnt_reg   <= CNT_INIT;
                  mem_addr  <= if_addr;
                  mem_write <= 1'b0;
                  mem_read  <= 1'b1;
                  grant     <= 2'b01;
               end
            end
            ACC_IF, ACC_DM: begin
               if (cnt_reg != 4'd0) begin
                  cnt_reg <= cnt_reg - 4'd1;
               end else begin
                  state_reg <= IDLE;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  grant     <= 2'b00;
                  if (state_reg == ACC_IF) begin
                     if_rdata <= mem_rdata;
                     if_ready <= 1'b1;
                  end else begin
                     // A write completes without touching dm_rdata.
                     if (!mem_write) begin
                        dm_rdata <= mem_rdata;
                     end
                     dm_ready <= 1'b1;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. A scoreboard queue holds the expected
// completions (port + data); entries are pushed when a request is driven and
// popped when the matching ready pulse is seen. A second instance runs with
// MEM_LAT=1 for the short-latency fetch case.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;

   // Instance A: MEM_LAT = 2
   logic        if_req, dm_read, dm_write;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_ready, dm_ready, mem_read, mem_write;
   logic [1:0]  grant;

   // Instance B: MEM_LAT = 1
   logic        if_req_b, dm_read_b, dm_write_b;
   logic [31:0] if_addr_b, dm_addr_b, dm_wdata_b;
   logic [31:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
   logic        if_ready_b, dm_ready_b, mem_read_b, mem_write_b;
   logic [1:0]  grant_b;

   typedef struct {
      int          port;   // 0: IF of A, 1: DM of A, 2: IF of B
      logic [31:0] data;
   } sb_entry_t;

   sb_entry_t sb[$];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Memory contents seen by both instances.
   function automatic logic [31:0] mem_model(input logic [31:0] a);
      case (a)
         32'h0000_0040: return 32'h8C22_0004;
         32'h0000_0044: return 32'h0085_1020;
         32'h0000_0100: return 32'h0000_BEEF;
         default:       return a ^ 32'hA5A5_A5A5;
      endcase
   endfunction

   assign mem_rdata   = mem_model(mem_addr);
   assign mem_rdata_b = mem_model(mem_addr_b);

   mem_port_arbiter #(.MEM_LAT(2)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
      .mem_write(mem_write), .mem_rdata(mem_rdata), .grant(grant)
   );

   mem_port_arbiter #(.MEM_LAT(1)) u_dut_b (
      .clk(clk), .rst(rst),
      .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b), .if_ready(if_ready_b),
      .dm_read(dm_read_b), .dm_write(dm_write_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
      .dm_rdata(dm_rdata_b), .dm_ready(dm_ready_b),
      .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_read(mem_read_b),
      .mem_write(mem_write_b), .mem_rdata(mem_rdata_b), .grant(grant_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic rdy(input int which);
      case (which)
         0:       return if_ready;
         1:       return dm_ready;
         default: return if_ready_b;
      endcase
   endfunction

   function automatic logic [31:0] rdata_of(input int which);
      case (which)
         0:       return if_rdata;
         1:       return dm_rdata;
         default: return if_rdata_b;
      endcase
   endfunction

   // Step until the selected ready is seen; n counts edges from the call.
   task automatic wait_ready(input string tag, input int which, input int max, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!rdy(which) && n < max);
      chk({tag, "_ready_seen"}, 32'(rdy(which)), 32'd1);
   endtask

   task automatic push(input int port, input logic [31:0] data);
      sb_entry_t e;
      e.port = port;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic pop_check(input string tag, input int which);
      sb_entry_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_port"}, 32'(which), 32'(e.port));
         chk({tag, "_data"}, rdata_of(which), e.data);
         $display("txn %s port=%0d data=%h expected=%h", tag, which, rdata_of(which), e.data);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      int n;
      int ready_hits;

      // ---- Reset with random inputs ----
      rst = 1'b1;
      if_req_b = 1'b0; dm_read_b = 1'b0; dm_write_b = 1'b0;
      if_addr_b = 32'd0; dm_addr_b = 32'd0; dm_wdata_b = 32'd0;
      for (int i = 0; i < 3; i++) begin
         if_req   = 1'($urandom);
         dm_read  = 1'($urandom);
         dm_write = 1'($urandom);
         if_addr  = $urandom;
         dm_addr  = $urandom;
         dm_wdata = $urandom;
         tick();
      end
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_strobes", {28'd0, mem_read, mem_write, if_ready, dm_ready}, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
      if_addr = 32'd0; dm_addr = 32'd0; dm_wdata = 32'd0;
      rst = 1'b0;
      tick(); tick(); tick();
      chk("post_rst_idle", {grant, mem_read, mem_write, if_ready, dm_ready}, 32'd0);
      chk("post_rst_addr", mem_addr, 32'd0);

      // ---- Lone fetch, MEM_LAT=2 ----
      if_req = 1'b1; if_addr = 32'h40;
      push(0, 32'h8C22_0004);
      tick();
      chk("fetch_c1_grant", 32'(grant), 32'd1);
      chk("fetch_c1_rd", 32'(mem_read), 32'd1);
      chk("fetch_c1_addr", mem_addr, 32'h40);
      tick();
      chk("fetch_c2_grant", 32'(grant), 32'd1);
      chk("fetch_c2_rd", 32'(mem_read), 32'd1);
      chk("fetch_c2_rdy", 32'(if_ready), 32'd0);
      tick();
      chk("fetch_c3_grant", 32'(grant), 32'd0);
      chk("fetch_c3_rd", 32'(mem_read), 32'd0);
      chk("fetch_c3_rdy", 32'(if_ready), 32'd1);
      pop_check("fetch", 0);
      if_req = 1'b0;
      tick();
      chk("fetch_pulse_len", 32'(if_ready), 32'd0);
      chk("fetch_rdata_hold", if_rdata, 32'h8C22_0004);

      // ---- Conflict: DM first, IF three cycles after dm_ready ----
      if_req = 1'b1; if_addr = 32'h44;
      dm_read = 1'b1; dm_addr = 32'h100;
      push(1, 32'h0000_BEEF);
      push(0, 32'h0085_1020);
      tick();
      chk("conf_grant_dm", 32'(grant), 32'd2);
      chk("conf_addr_dm", mem_addr, 32'h100);
      wait_ready("conf_dm", 1, 10, n);
      chk("conf_dm_lat", 32'(n), 32'd2);
      pop_check("conf_dm", 1);
      dm_read = 1'b0;
      tick();
      chk("conf_grant_if", 32'(grant), 32'd1);
      chk("conf_addr_if", mem_addr, 32'h44);
      wait_ready("conf_if", 0, 10, n);
      chk("conf_if_after_dm", 32'(n + 1), 32'd3);
      pop_check("conf_if", 0);
      if_req = 1'b0;
      tick();

      // ---- Write with both dm_read and dm_write high ----
      dm_read = 1'b1; dm_write = 1'b1;
      dm_addr = 32'h200; dm_wdata = 32'hCAFE_F00D;
      push(1, 32'h0000_BEEF);
      tick();
      chk("wr_c1_wr", 32'(mem_write), 32'd1);
      chk("wr_c1_rd", 32'(mem_read), 32'd0);
      chk("wr_c1_wdata", mem_wdata, 32'hCAFE_F00D);
      chk("wr_c1_addr", mem_addr, 32'h200);
      tick();
      chk("wr_c2_wr", 32'(mem_write), 32'd1);
      tick();
      chk("wr_c3_rdy", 32'(dm_ready), 32'd1);
      chk("wr_c3_wr", 32'(mem_write), 32'd0);
      pop_check("write", 1);
      dm_read = 1'b0; dm_write = 1'b0;
      tick();
      chk("wr_idle_wdata_hold", mem_wdata, 32'hCAFE_F00D);

      // ---- Exclusion: if_req held through if_ready ----
      if_req = 1'b1; if_addr = 32'h80;
      push(0, mem_model(32'h80));
      wait_ready("excl_1", 0, 10, n);
      chk("excl_1_lat", 32'(n), 32'd3);
      pop_check("excl_1", 0);
      if_addr = 32'h84;
      push(0, mem_model(32'h84));
      tick();
      chk("excl_no_regrant", 32'(grant), 32'd0);
      chk("excl_no_read", 32'(mem_read), 32'd0);
      tick();
      chk("excl_regrant", 32'(grant), 32'd1);
      chk("excl_regrant_addr", mem_addr, 32'h84);
      wait_ready("excl_2", 0, 10, n);
      chk("excl_2_lat", 32'(n), 32'd2);
      pop_check("excl_2", 0);
      if_req = 1'b0;
      tick();

      // ---- Lone fetch, MEM_LAT=1 ----
      if_req_b = 1'b1; if_addr_b = 32'h40;
      push(2, 32'h8C22_0004);
      tick();
      chk("lat1_rd", 32'(mem_read_b), 32'd1);
      chk("lat1_grant", 32'(grant_b), 32'd1);
      tick();
      chk("lat1_rdy", 32'(if_ready_b), 32'd1);
      pop_check("lat1", 2);
      if_req_b = 1'b0;
      tick();
      chk("lat1_pulse_len", 32'(if_ready_b), 32'd0);

      // ---- Reset during the second cycle of a write ----
      dm_write = 1'b1; dm_addr = 32'h300; dm_wdata = 32'h1234_5678;
      tick();
      tick();
      chk("mid_wr_active", 32'(mem_write), 32'd1);
      ready_hits = 0;
      rst = 1'b1;
      #1;
      chk("mid_wr_async_drop", 32'(mem_write), 32'd0);
      chk("mid_grant", 32'(grant), 32'd0);
      chk("mid_addr_clr", mem_addr, 32'd0);
      chk("mid_wdata_clr", mem_wdata, 32'd0);
      dm_write = 1'b0;
      tick();
      if (dm_ready) ready_hits++;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (dm_ready) ready_hits++;
      end
      chk("mid_no_ready", 32'(ready_hits), 32'd0);
      chk("mid_idle", {grant, mem_read, mem_write}, 32'd0);
      if_req = 1'b1; if_addr = 32'h40;
      push(0, 32'h8C22_0004);
      wait_ready("post_mid", 0, 10, n);
      chk("post_mid_lat", 32'(n), 32'd3);
      pop_check("post_mid", 0);
      if_req = 1'b0;
      tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
